mpu_rx_pack: RTL and testbench

- Sits between the I2C master's read-data output and the measurement RAM (OPM).
- Consumes the bytes of one MPU-6050 burst read and assembles MSB-first byte pairs into 16-bit signed words.
- Writes each word into the RAM address fixed for its measurement, then signals completion to the controller FSM.
- Also flags mis-sized transfers and bus stalls.

---
 rtl/mpu_rx_pack.sv | 212 +++++++++++++++++++++
 tb/tb_mpu_rx_pack.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_rx_pack.sv
`default_nettype none
// ============================================================================
// Module      : mpu_rx_pack
// Description : Packs the bytes of one MPU-6050 burst read, MSB first, into
//               16-bit raw two's-complement words. Each word is written to
//               the measurement RAM address reserved for it. Completion,
//               mis-sized transfers and bus stalls are reported to the
//               controller.
// Ports       : CLK/RST_n            clock, asynchronous active-low reset
//               I_START/I_KIND       begin a transfer of the given kind
//               I_BYTE_VLD/I_BYTE    received byte strobe and data
//               I_ABORT              controller abort (NACK / bus error)
//               O_WE/O_ADDR/O_DATA   RAM write port (single-cycle strobe)
//               O_BUSY               transfer in progress
//               O_DONE               pulse after the last word is written
//               O_ERR                pulse on illegal kind, timeout or abort
// Revision    : 1.0 - initial release
// ============================================================================
module mpu_rx_pack #(
    parameter int DATA_I2C_SZ = 8,
    parameter int DATA_OPM_SZ = 16,
    parameter int ADDR_OPM_SZ = 4,
    parameter int TIMEOUT     = 2048
) (
    input  logic                   CLK,
    input  logic                   RST_n,
    input  logic                   I_START,
    input  logic [2:0]             I_KIND,
    input  logic                   I_BYTE_VLD,
    input  logic [DATA_I2C_SZ-1:0] I_BYTE,
    input  logic                   I_ABORT,
    output logic                   O_WE,
    output logic [ADDR_OPM_SZ-1:0] O_ADDR,
    output logic [DATA_OPM_SZ-1:0] O_DATA,
    output logic                   O_BUSY,
    output logic                   O_DONE,
    output logic                   O_ERR
);

    localparam int              c_TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_LO   = 2'd2,
        S_LAST = 2'd3
    } state_t;

    state_t                 r_state, w_state_nx;
    logic                   r_who, w_who;
    logic [ADDR_OPM_SZ-1:0] r_base, w_base;
    logic [1:0]             r_nwords, w_nwords;
    logic [1:0]             r_idx, w_idx;
    logic [DATA_I2C_SZ-1:0] r_msb, w_msb;
    logic [c_TMO_W-1:0]     r_tmo, w_tmo;
    logic                   r_we, w_we;
    logic [ADDR_OPM_SZ-1:0] r_addr, w_addr;
    logic [DATA_OPM_SZ-1:0] r_data, w_data;
    logic                   r_done, w_done;
    logic                   r_err, w_err;

    // Kind decode: legality, base address, word count, single-byte flag
    logic                   w_kind_ok;
    logic [ADDR_OPM_SZ-1:0] w_kind_base;
    logic [1:0]             w_kind_n;
    logic                   w_kind_who;
    logic                   w_tmo_hit;
    logic [1:0]             w_idx_inc;

    always_comb begin
        w_kind_ok   = 1'b1;
        w_kind_base = '0;
        w_kind_n    = 2'd1;
        w_kind_who  = 1'b0;
        case (I_KIND)
            3'd0: begin w_kind_base = ADDR_OPM_SZ'(1); w_kind_n = 2'd3; end
            3'd1: begin w_kind_base = ADDR_OPM_SZ'(0); w_kind_n = 2'd1; end
            3'd2: begin w_kind_base = ADDR_OPM_SZ'(4); w_kind_n = 2'd3; end
            3'd3: begin w_kind_base = ADDR_OPM_SZ'(7); w_kind_n = 2'd1; end
            3'd4: begin
                w_kind_base = ADDR_OPM_SZ'(8);
                w_kind_n    = 2'd1;
                w_kind_who  = 1'b1;
            end
            default: w_kind_ok = 1'b0;
        endcase
    end

    // The stall counter saturates at the last legal value; reaching it with
    // no byte arriving is the timeout.
    assign w_tmo_hit = (r_tmo == c_TMO_LAST);
    assign w_idx_inc = r_idx + 2'd1;

    always_comb begin
        w_state_nx = r_state;
        w_who      = r_who;
        w_base     = r_base;
        w_nwords   = r_nwords;
        w_idx      = r_idx;
        w_msb      = r_msb;
        w_tmo      = r_tmo;
        w_we       = 1'b0;
        w_addr     = r_addr;
        w_data     = r_data;
        w_done     = 1'b0;
        w_err      = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Bytes arriving here (including alongside I_START) are dropped
                if (I_START) begin
                    if (w_kind_ok) begin
                        w_who      = w_kind_who;
                        w_base     = w_kind_base;
                        w_nwords   = w_kind_n;
                        w_idx      = 2'd0;
                        w_tmo      = '0;
                        w_state_nx = w_kind_who ? S_LO : S_HI;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end

            S_HI: begin
                if (I_ABORT || w_tmo_hit) begin
                    w_err      = 1'b1;
                    w_msb      = '0;
                    w_state_nx = S_IDLE;
                end else if (I_BYTE_VLD) begin
                    w_msb      = I_BYTE;
                    w_tmo      = '0;
                    w_state_nx = S_LO;
                end else begin
                    w_tmo = r_tmo + c_TMO_W'(1);
                end
            end

            S_LO: begin
                if (I_ABORT || w_tmo_hit) begin
                    // A pending MSB is discarded, nothing is written
                    w_err      = 1'b1;
                    w_msb      = '0;
                    w_state_nx = S_IDLE;
                end else if (I_BYTE_VLD) begin
                    w_we   = 1'b1;
                    w_addr = r_base + ADDR_OPM_SZ'(r_idx);
                    w_data = r_who ? DATA_OPM_SZ'(I_BYTE)
                                   : DATA_OPM_SZ'({r_msb, I_BYTE});
                    w_idx  = w_idx_inc;
                    w_tmo  = '0;
                    w_state_nx = (w_idx_inc < r_nwords) ? S_HI : S_LAST;
                end else begin
                    w_tmo = r_tmo + c_TMO_W'(1);
                end
            end

            S_LAST: begin
                // Write strobe is on the bus this cycle; DONE follows it
                if (I_ABORT) begin
                    w_err = 1'b1;
                end else begin
                    w_done = 1'b1;
                end
                w_state_nx = S_IDLE;
            end

            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state  <= S_IDLE;
            r_who    <= 1'b0;
            r_base   <= '0;
            r_nwords <= 2'd0;
            r_idx    <= 2'd0;
            r_msb    <= '0;
            r_tmo    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_who    <= w_who;
            r_base   <= w_base;
            r_nwords <= w_nwords;
            r_idx    <= w_idx;
            r_msb    <= w_msb;
            r_tmo    <= w_tmo;
            r_we     <= w_we;
            r_addr   <= w_addr;
            r_data   <= w_data;
            r_done   <= w_done;
            r_err    <= w_err;
        end
    end

    assign O_WE   = r_we;
    assign O_ADDR = r_addr;
    assign O_DATA = r_data;
    // BUSY falls in the same cycle DONE rises, as state returns to IDLE
    assign O_BUSY = (r_state != S_IDLE);
    assign O_DONE = r_done;
    assign O_ERR  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mpu_rx_pack.sv
`default_nettype none
// ============================================================================
// Module      : tb_mpu_rx_pack
// Description : Self-checking bench for mpu_rx_pack. Stimulus pushes the
//               expected write/done/error events (with their cycle) into a
//               scoreboard queue; a monitor pops and compares whenever the
//               DUT presents O_WE, O_DONE or O_ERR.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mpu_rx_pack;

    localparam int TMO = 2048;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        I_START = 1'b0;
    logic [2:0]  I_KIND = 3'd0;
    logic        I_BYTE_VLD = 1'b0;
    logic [7:0]  I_BYTE = 8'h00;
    logic        I_ABORT = 1'b0;
    logic        O_WE;
    logic [3:0]  O_ADDR;
    logic [15:0] O_DATA;
    logic        O_BUSY;
    logic        O_DONE;
    logic        O_ERR;

    mpu_rx_pack #(
        .DATA_I2C_SZ(8),
        .DATA_OPM_SZ(16),
        .ADDR_OPM_SZ(4),
        .TIMEOUT    (TMO)
    ) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .I_START   (I_START),
        .I_KIND    (I_KIND),
        .I_BYTE_VLD(I_BYTE_VLD),
        .I_BYTE    (I_BYTE),
        .I_ABORT   (I_ABORT),
        .O_WE      (O_WE),
        .O_ADDR    (O_ADDR),
        .O_DATA    (O_DATA),
        .O_BUSY    (O_BUSY),
        .O_DONE    (O_DONE),
        .O_ERR     (O_ERR)
    );

    always #10 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // Event types: 0 = write, 1 = done, 2 = error
    typedef struct {
        int          typ;
        logic [3:0]  addr;
        logic [15:0] data;
        int          cyc;
    } ev_t;

    ev_t q[$];

    task automatic push_ev(input int typ, input logic [3:0] a,
                           input logic [15:0] d, input int c);
        ev_t e;
        e.typ  = typ;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic exp_wr(input logic [3:0] a, input logic [15:0] d, input int c);
        push_ev(0, a, d, c);
    endtask

    task automatic exp_done(input int c);
        push_ev(1, 4'h0, 16'h0000, c);
    endtask

    task automatic exp_err(input int c);
        push_ev(2, 4'h0, 16'h0000, c);
    endtask

    // Monitor side of the scoreboard
    task automatic take(input int typ);
        ev_t e;
        n_chk++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got type %0d addr %0h data %h at cycle %0d, expected no event",
                     typ, O_ADDR, O_DATA, cyc);
        end else begin
            e = q.pop_front();
            if (e.typ != typ || e.cyc != cyc ||
                (typ == 0 && (e.addr != O_ADDR || e.data != O_DATA))) begin
                n_fail++;
                $display("FAIL event: got type %0d addr %0h data %h cycle %0d, expected type %0d addr %0h data %h cycle %0d",
                         typ, O_ADDR, O_DATA, cyc, e.typ, e.addr, e.data, e.cyc);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (RST_n === 1'b1) begin
            if (O_WE   === 1'b1) take(0);
            if (O_DONE === 1'b1) take(1);
            if (O_ERR  === 1'b1) take(2);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Each call advances to just after the next rising edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) step();
    endtask

    task automatic start(input logic [2:0] k);
        I_START = 1'b1;
        I_KIND  = k;
        step();
        I_START = 1'b0;
    endtask

    task automatic send_msb(input logic [7:0] b, output int c);
        I_BYTE_VLD = 1'b1;
        I_BYTE     = b;
        c          = cyc;
        step();
        I_BYTE_VLD = 1'b0;
    endtask

    task automatic send_lsb(input logic [7:0] b, input logic [3:0] a,
                            input logic [15:0] d, output int c);
        I_BYTE_VLD = 1'b1;
        I_BYTE     = b;
        c          = cyc;
        exp_wr(a, d, c + 1);
        step();
        I_BYTE_VLD = 1'b0;
    endtask

    task automatic word(input logic [7:0] hi, input logic [7:0] lo,
                        input logic [3:0] a, input int sp, output int c);
        int cm;
        send_msb(hi, cm);
        gap(sp);
        send_lsb(lo, a, {hi, lo}, c);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected test end", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;

        // Reset state
        gap(3);
        chk("reset_outputs", {13'd0, O_WE, O_ADDR, O_DATA, O_BUSY, O_DONE, O_ERR}, 32'd0);
        RST_n = 1'b1;
        step();

        // accel, bytes spaced 1125 clocks
        start(3'd0);
        chk("accel_busy_after_start", {31'd0, O_BUSY}, 32'd1);
        for (int w = 0; w < 3; w++) begin
            word(8'hF0, 8'hB0, 4'(1 + w), 1124, c);
            if (w < 2) gap(1124);
        end
        exp_done(c + 2);
        chk("accel_busy_last", {31'd0, O_BUSY}, 32'd1);
        step();
        chk("accel_busy_at_done", {31'd0, O_BUSY}, 32'd0);

        // temp then gyro back-to-back
        start(3'd1);
        word(8'hF0, 8'hB0, 4'd0, 2, c);
        exp_done(c + 2);
        step();
        start(3'd2);
        word(8'h01, 8'h02, 4'd4, 2, c);
        gap(2);
        word(8'h03, 8'h04, 4'd5, 2, c);
        gap(2);
        word(8'h05, 8'h06, 4'd6, 2, c);
        exp_done(c + 2);
        step();
        gap(2);

        // who_am_i twice; second run has a byte alongside START (dropped)
        start(3'd4);
        send_lsb(8'h68, 4'd8, 16'h0068, c);
        exp_done(c + 2);
        step();
        I_START    = 1'b1;
        I_KIND     = 3'd4;
        I_BYTE_VLD = 1'b1;
        I_BYTE     = 8'h55;
        step();
        I_START    = 1'b0;
        I_BYTE_VLD = 1'b0;
        gap(1);
        send_lsb(8'h69, 4'd8, 16'h0069, c);
        exp_done(c + 2);
        step();
        gap(2);

        // Illegal kind
        I_START = 1'b1;
        I_KIND  = 3'd5;
        exp_err(cyc + 1);
        step();
        I_START = 1'b0;
        chk("illegal_kind_busy", {31'd0, O_BUSY}, 32'd0);
        gap(3);
        chk("illegal_kind_busy_later", {31'd0, O_BUSY}, 32'd0);

        // gyro with three bytes then silence
        start(3'd2);
        word(8'hA1, 8'hA2, 4'd4, 3, c);
        gap(3);
        send_msb(8'hA3, c);
        exp_err(c + 1 + TMO);
        gap(TMO + 3);
        chk("timeout_back_idle", {31'd0, O_BUSY}, 32'd0);

        // accel aborted after three bytes, then a clean accel with a
        // stray START while busy
        start(3'd0);
        word(8'hF0, 8'hB0, 4'd1, 2, c);
        gap(2);
        send_msb(8'h11, c);
        gap(2);
        I_ABORT = 1'b1;
        exp_err(cyc + 1);
        step();
        I_ABORT = 1'b0;
        chk("abort_back_idle", {31'd0, O_BUSY}, 32'd0);
        gap(2);
        start(3'd0);
        word(8'h12, 8'h34, 4'd1, 1, c);
        gap(1);
        start(3'd4);
        word(8'h56, 8'h78, 4'd2, 1, c);
        gap(1);
        word(8'h9A, 8'hBC, 4'd3, 1, c);
        exp_done(c + 2);
        step();
        gap(2);

        // Asynchronous reset after an MSB
        start(3'd0);
        send_msb(8'h7F, c);
        gap(1);
        chk("busy_before_reset", {31'd0, O_BUSY}, 32'd1);
        RST_n = 1'b0;
        #1;
        chk("async_reset_outputs", {13'd0, O_WE, O_ADDR, O_DATA, O_BUSY, O_DONE, O_ERR}, 32'd0);
        gap(2);
        RST_n = 1'b1;
        step();

        // fifo_count; an extra byte during LAST is dropped
        start(3'd3);
        word(8'h01, 8'h2C, 4'd7, 1, c);
        exp_done(c + 2);
        send_msb(8'hEE, c);
        gap(4);
        chk("final_busy", {31'd0, O_BUSY}, 32'd0);

        chk("leftover_expected_events", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
